pipelined_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 26 ++
 rtl/adder_chunk.sv | 28 ++
 rtl/pipelined_adder.sv | 133 +++++++++++++
 tb/tb_pipelined_adder.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder: default sizing, the
// WIDTH/CHUNK legality test, the full-adder cell and the stage-register layout.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    function automatic bit chunk_legal(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

    // Returns {carry_out, sum}.
    function automatic logic [1:0] fulladd(input logic a, input logic b, input logic ci);
        return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

    // Stage register layout at the default width; the top re-declares it at WIDTH.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [DEF_WIDTH-1:0] sum_lo;
        logic [DEF_WIDTH-1:0] x_hi;
        logic [DEF_WIDTH-1:0] y_hi;
    } stage_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
module adder_chunk
    import adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    always_comb begin
        logic       c;
        logic [1:0] fa;
        s  = '0;
        fa = '0;
        c  = ci;
        for (int i = 0; i < CHUNK; i++) begin
            fa   = fulladd(a[i], b[i], c);
            s[i] = fa[0];
            c    = fa[1];
        end
        co = c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract with the carry chain cut into CHUNK-bit pipeline stages.
// Defining PIPELINED_ADDER_OVF_EN adds the signed-overflow output ovf.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSTAGE = WIDTH / CHUNK;

    if (!chunk_legal(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] sum_lo;
        logic [WIDTH-1:0] x_hi;
        logic [WIDTH-1:0] y_hi;
    } stage_w_t;

    stage_w_t         st_q  [NSTAGE];
    stage_w_t         st_in [NSTAGE];
    stage_w_t         st_d  [NSTAGE];
    logic             adv   [NSTAGE+1];
    logic [CHUNK-1:0] ch_s  [NSTAGE];
    logic             ch_co [NSTAGE];

    // Stall chain runs from the output back to the input so a full pipeline
    // can accept and emit in the same cycle.
    always_comb begin
        adv[NSTAGE] = out_ready;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            adv[k] = !st_q[k].valid || adv[k+1];
        end
        st_in[0].valid  = in_valid;
        st_in[0].carry  = cin ^ sub;
        st_in[0].sum_lo = '0;
        st_in[0].x_hi   = x;
        st_in[0].y_hi   = y ^ {WIDTH{sub}};
        for (int k = 1; k < NSTAGE; k++) begin
            st_in[k] = st_q[k-1];
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a  (st_in[k].x_hi[k*CHUNK +: CHUNK]),
            .b  (st_in[k].y_hi[k*CHUNK +: CHUNK]),
            .ci (st_in[k].carry),
            .s  (ch_s[k]),
            .co (ch_co[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            st_d[k]                           = st_in[k];
            st_d[k].carry                     = ch_co[k];
            st_d[k].sum_lo[k*CHUNK +: CHUNK]  = ch_s[k];
        end
    end

    // Data only loads with a valid beat, so s/cout hold while the pipe drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                if (adv[k]) begin
                    st_q[k].valid <= st_d[k].valid;
                    if (st_d[k].valid) begin
                        st_q[k].carry  <= st_d[k].carry;
                        st_q[k].sum_lo <= st_d[k].sum_lo;
                        st_q[k].x_hi   <= st_d[k].x_hi;
                        st_q[k].y_hi   <= st_d[k].y_hi;
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = st_q[NSTAGE-1].valid;
    assign s         = st_q[NSTAGE-1].sum_lo;
    assign cout      = st_q[NSTAGE-1].carry;

`ifdef PIPELINED_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // The MSB is added in the last stage: overflow when both addends share a
    // sign and the sum's sign differs.
    always_comb begin
        ovf_d = (st_in[NSTAGE-1].x_hi[WIDTH-1] ~^ st_in[NSTAGE-1].y_hi[WIDTH-1])
              & (ch_s[NSTAGE-1][CHUNK-1] ^ st_in[NSTAGE-1].x_hi[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv[NSTAGE-1] && st_d[NSTAGE-1].valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (16/4 main instance, 8/8 single-stage instance).
module tb_pipelined_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [W-1:0] x, y, s;
    logic         in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8;
    logic [7:0]   x8, y8, s8;
`ifdef PIPELINED_ADDER_OVF_EN
    logic         ovf, ovf8;
`endif

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    pipelined_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .x         (x8),
        .y         (y8),
        .cin       (cin8),
        .sub       (sub8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .s         (s8),
        .cout      (cout8)
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .ovf       (ovf8)
`endif
    );

    typedef struct {
        logic [W:0] res;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total   = 0;
    int   bad     = 0;
    int   n_pop   = 0;
    int   run_len = 0;
    int   max_run = 0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic su);
        exp_t       e;
        logic [W-1:0] bb;
        logic       ce;
        int         sr;
        bb    = su ? ~b : b;
        ce    = ci ^ su;
        e.res = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ce};
        sr    = int'($signed(a)) + int'($signed(bb)) + int'(ce);
        e.ovf = (sr > 32767) || (sr < -32768);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            run_len = 0;
        end else begin
            if (out_valid && out_ready) begin
                n_pop++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                total++;
                assert (sb.size() > 0) else begin
                    bad++;
                    $error("FAIL sb_unexpected got=%0h exp=none", {cout, s});
                end
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    total++;
                    assert ({cout, s} === mon_e.res) else begin
                        bad++;
                        $error("FAIL sb_result got=%0h exp=%0h", {cout, s}, mon_e.res);
                    end
`ifdef PIPELINED_ADDER_OVF_EN
                    total++;
                    assert (ovf === mon_e.ovf) else begin
                        bad++;
                        $error("FAIL sb_ovf got=%0b exp=%0b", ovf, mon_e.ovf);
                    end
`endif
                end
            end else begin
                run_len = 0;
            end
            if (in_valid && in_ready) sb.push_back(model(x, y, cin, sub));
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic su);
        int g;
        g        = 0;
        x        = a;
        y        = b;
        cin      = c;
        sub      = su;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            total++;
            bad++;
            $error("FAIL send_timeout got=in_ready_low exp=in_ready_high");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cnt);
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sb.size() != 0 || out_valid) && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, acc, p0, stale;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        x          = '0;
        y          = '0;
        cin        = 1'b0;
        sub        = 1'b0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        x8         = '0;
        y8         = '0;
        cin8       = 1'b0;
        sub8       = 1'b0;
        out_ready8 = 1'b1;

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_cout", cout, 0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // Carry ripples through every stage
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_out(lat);
        check("lat_ffff", lat, 4);
        check("s_ffff", s, 16'h0000);
        check("cout_ffff", cout, 1);
        drain();

        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_out(lat);
        check("lat_sub", lat, 4);
        check("s_sub", s, 16'hFFFE);
        check("cout_sub", cout, 0);
        drain();

        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_out(lat);
        check("s_sub_borrow", s, 16'hFFFD);
        check("cout_sub_borrow", cout, 0);
        drain();

`ifdef PIPELINED_ADDER_OVF_EN
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_out(lat);
        check("ovf_7fff", ovf, 1);
        check("s_7fff", s, 16'h8000);
        drain();
`endif

        // Back-to-back stream at full throughput
        max_run = 0;
        p0      = n_pop;
        for (int i = 0; i < 8; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();
        check("b2b_run", max_run, 8);
        check("b2b_pops", n_pop - p0, 8);

        // Downstream stall: pipe fills to 4 then back-pressures
        out_ready = 1'b0;
        acc       = 0;
        p0        = n_pop;
        for (int i = 0; i < 6; i++) begin
            x        = W'($urandom);
            y        = W'($urandom);
            cin      = 1'($urandom);
            sub      = 1'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stall_accepted", acc, 4);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("full_release_in_ready", in_ready, 1);
        drain();
        check("stall_pops", n_pop - p0, 4);

        // Reset with beats in flight
        out_ready = 1'b0;
        p0        = n_pop;
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b0, 1'b0);
        send(16'h5555, 16'h0001, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("inflight_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_s", s, 0);
        check("midrst_cout", cout, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        stale     = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale", stale, 0);
        check("midrst_pops", n_pop - p0, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_out(lat);
        check("lat_after_rst", lat, 4);
        check("s_after_rst", s, 16'h5555);
        drain();

        // Single-stage variant: result one edge after acceptance
        x8        = 8'h80;
        y8        = 8'h80;
        in_valid8 = 1'b1;
        @(negedge clk);
        check("w8_in_ready", in_ready8, 1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        check("w8_out_valid", out_valid8, 1);
        check("w8_s", s8, 8'h00);
        check("w8_cout", cout8, 1);
`ifdef PIPELINED_ADDER_OVF_EN
        check("w8_ovf", ovf8, 1);
`endif
        @(posedge clk);
        #1;
        check("w8_consumed", out_valid8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
